// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the CPU-to-SRAM memory bridge.
// The memory-mapped I/O at IO_ADDR only exists when MEM_BRIDGE_IO_EN is defined.
package mem_bridge_pkg;

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StWrec} state_e;

  localparam logic [15:0] IO_ADDR = 16'hFFFF;

  // Active-low gfedcba segments; entry 15 first so SEG_TABLE[n] is digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/mem_bridge_hex.sv
// Nibble to active-low seven-segment decoder.
module hex_decode (
  input  logic [3:0] nibble,
  output logic [6:0] segs
);
  import mem_bridge_pkg::*;

  assign segs = SEG_TABLE[nibble];

endmodule

// File: rtl/mem_bridge.sv
// Bridge between the CPU MAR/MDR strobes and an asynchronous SRAM.
// Define MEM_BRIDGE_IO_EN to map switches/hex display at address 16'hFFFF.
module mem_bridge (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_from_CPU,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [15:0] Switches,
  output logic [15:0] Data_to_CPU,
  output logic [19:0] SRAM_ADDR,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  input  logic [15:0] SRAM_DQ_In,
  output logic [15:0] SRAM_DQ_Out,
  output logic        SRAM_DQ_Drive,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3
);
  import mem_bridge_pkg::*;

  state_e      state_q;
  logic [15:0] addr_q;
  logic [15:0] data_q;
  logic [15:0] rdata_q;
  logic [15:0] read_src;
  logic        io_wr;
  logic        in_write;

`ifdef MEM_BRIDGE_IO_EN
  logic [15:0] hex_q;

  assign read_src = (ADDR == IO_ADDR) ? Switches : SRAM_DQ_In;
  assign io_wr    = (addr_q == IO_ADDR);

  hex_decode u_hex0 (.nibble(hex_q[3:0]),   .segs(HEX0));
  hex_decode u_hex1 (.nibble(hex_q[7:4]),   .segs(HEX1));
  hex_decode u_hex2 (.nibble(hex_q[11:8]),  .segs(HEX2));
  hex_decode u_hex3 (.nibble(hex_q[15:12]), .segs(HEX3));
`else
  logic unused_sw;

  assign unused_sw = ^Switches;
  assign read_src  = SRAM_DQ_In;
  assign io_wr     = 1'b0;
  assign HEX0      = 7'h7F;
  assign HEX1      = 7'h7F;
  assign HEX2      = 7'h7F;
  assign HEX3      = 7'h7F;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
`ifdef MEM_BRIDGE_IO_EN
      hex_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          // A write strobe wins over a simultaneous read strobe.
          if (!Mem_WE) begin
            addr_q  <= ADDR;
            data_q  <= Data_from_CPU;
            state_q <= StWrite;
          end else if (!Mem_OE) begin
            rdata_q <= read_src;
            state_q <= StRead;
          end
        end
        StRead: begin
          if (!Mem_OE) begin
            rdata_q <= read_src;
          end else begin
            state_q <= StIdle;
          end
        end
        StWrite: begin
`ifdef MEM_BRIDGE_IO_EN
          if (io_wr) begin
            hex_q <= data_q;
          end
`endif
          state_q <= StWrec;
        end
        StWrec: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs decode straight from the async-reset state, so Reset drops WE at once.
  assign in_write      = (state_q == StWrite) || (state_q == StWrec);
  assign SRAM_ADDR     = {4'h0, in_write ? addr_q : ADDR};
  assign SRAM_CE_N     = Reset;
  assign SRAM_OE_N     = Reset | in_write | Mem_OE;
  assign SRAM_DQ_Drive = (state_q == StWrite) && !io_wr;
  assign SRAM_WE_N     = !SRAM_DQ_Drive;
  assign SRAM_DQ_Out   = data_q;
  assign Data_to_CPU   = rdata_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Scoreboard bench for mem_bridge with a behavioural SRAM model.
module tb_mem_bridge;

  logic        Clk;
  logic        Reset;
  logic [15:0] ADDR;
  logic [15:0] Data_from_CPU;
  logic        Mem_OE;
  logic        Mem_WE;
  logic [15:0] Switches;
  logic [15:0] Data_to_CPU;
  logic [19:0] SRAM_ADDR;
  logic        SRAM_CE_N;
  logic        SRAM_OE_N;
  logic        SRAM_WE_N;
  logic [15:0] SRAM_DQ_In;
  logic [15:0] SRAM_DQ_Out;
  logic        SRAM_DQ_Drive;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3;

  mem_bridge dut (
    .Clk(Clk), .Reset(Reset), .ADDR(ADDR), .Data_from_CPU(Data_from_CPU),
    .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .Switches(Switches), .Data_to_CPU(Data_to_CPU),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
    .SRAM_WE_N(SRAM_WE_N), .SRAM_DQ_In(SRAM_DQ_In), .SRAM_DQ_Out(SRAM_DQ_Out),
    .SRAM_DQ_Drive(SRAM_DQ_Drive), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // SRAM model: reads while OE_N low, writes mid-cycle while WE_N low.
  logic [15:0] mem [0:65535];
  assign SRAM_DQ_In = SRAM_OE_N ? 16'hDEAD : mem[SRAM_ADDR[15:0]];
  always @(negedge Clk) begin
    if (SRAM_WE_N === 1'b0 && SRAM_DQ_Drive === 1'b1) mem[SRAM_ADDR[15:0]] <= SRAM_DQ_Out;
  end

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_item_t;

  wr_item_t    wr_q[$];
  logic [15:0] rd_q[$];
  logic        rd_phase2;
  logic [15:0] last_rd;
  int          n_chk;
  int          n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a write appears when SRAM_WE_N drops; read data on the MDR-load cycle.
  always @(negedge Clk) begin
    if (!Reset && SRAM_WE_N === 1'b0) begin
      if (wr_q.size() == 0) begin
        chk("unexpected_sram_write", {12'h0, SRAM_ADDR}, 32'hFFFF_FFFF);
      end else begin
        wr_item_t w;
        w = wr_q.pop_front();
        chk("wr_addr", {12'h0, SRAM_ADDR}, {16'h0, w.addr});
        chk("wr_data", {16'h0, SRAM_DQ_Out}, {16'h0, w.data});
        chk("wr_drive", {31'h0, SRAM_DQ_Drive}, 32'h1);
        chk("wr_oe_n", {31'h0, SRAM_OE_N}, 32'h1);
      end
    end
    if (rd_phase2) begin
      if (rd_q.size() == 0) begin
        chk("read_without_expectation", 32'h0, 32'h1);
      end else begin
        logic [15:0] e;
        e = rd_q.pop_front();
        chk("rd_data", {16'h0, Data_to_CPU}, {16'h0, e});
        chk("rd_we_n", {31'h0, SRAM_WE_N}, 32'h1);
      end
    end
  end

  task automatic do_read(input logic [15:0] a, input logic [15:0] exp);
    @(posedge Clk); #1;
    ADDR = a; Mem_OE = 1'b0; Mem_WE = 1'b1;
    rd_q.push_back(exp);
    @(posedge Clk); #1;
    rd_phase2 = 1'b1;
    @(posedge Clk); #1;
    rd_phase2 = 1'b0; Mem_OE = 1'b1;
    last_rd = exp;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d, input bit with_oe,
                          input bit to_sram);
    @(posedge Clk); #1;
    ADDR = a; Data_from_CPU = d; Mem_WE = 1'b0; Mem_OE = with_oe ? 1'b0 : 1'b1;
    if (to_sram) wr_q.push_back('{addr: a, data: d});
    @(posedge Clk); #1;
    // Move the live address away so the latched one must be used.
    Mem_WE = 1'b1; ADDR = 16'h0777; Data_from_CPU = 16'h0;
    @(negedge Clk);
    @(negedge Clk);
    chk("wrec_we_n", {31'h0, SRAM_WE_N}, 32'h1);
    chk("wrec_drive", {31'h0, SRAM_DQ_Drive}, 32'h0);
    chk("wrec_oe_n", {31'h0, SRAM_OE_N}, 32'h1);
    chk("wrec_mdr_hold", {16'h0, Data_to_CPU}, {16'h0, last_rd});
    @(posedge Clk); #1;
    Mem_OE = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; rd_phase2 = 1'b0; last_rd = 16'h0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
    mem[16'h0040] = 16'h1234;
    mem[16'hFFFF] = 16'hC0DE;
    Switches = 16'hA5C3;
    ADDR = 16'h0040; Data_from_CPU = 16'h0;
    Mem_OE = 1'b0; Mem_WE = 1'b0;
    Reset = 1'b1;

    #3;
    chk("rst_mdr", {16'h0, Data_to_CPU}, 32'h0);
    chk("rst_ce_n", {31'h0, SRAM_CE_N}, 32'h1);
    chk("rst_oe_n", {31'h0, SRAM_OE_N}, 32'h1);
    chk("rst_we_n", {31'h0, SRAM_WE_N}, 32'h1);
    chk("rst_drive", {31'h0, SRAM_DQ_Drive}, 32'h0);
`ifdef MEM_BRIDGE_IO_EN
    chk("rst_hex", {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, 7'h40, 7'h40, 7'h40, 7'h40});
`else
    chk("rst_hex", {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, 7'h7F, 7'h7F, 7'h7F, 7'h7F});
`endif
    Mem_OE = 1'b1; Mem_WE = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    #1;
    chk("ce_n_active", {31'h0, SRAM_CE_N}, 32'h0);

    do_read(16'h0040, 16'h1234);
    do_write(16'h0100, 16'hBEEF, 1'b0, 1'b1);
    do_read(16'h0100, 16'hBEEF);
    do_write(16'h0200, 16'h5A5A, 1'b1, 1'b1);
    do_read(16'h0200, 16'h5A5A);

`ifdef MEM_BRIDGE_IO_EN
    do_read(16'hFFFF, 16'hA5C3);
    do_write(16'hFFFF, 16'h0123, 1'b0, 1'b0);
    chk("io_hex", {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, 7'h40, 7'h79, 7'h24, 7'h30});
`else
    do_read(16'hFFFF, 16'hC0DE);
    do_write(16'hFFFF, 16'h0123, 1'b0, 1'b1);
    chk("hex_blank", {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, 7'h7F, 7'h7F, 7'h7F, 7'h7F});
    do_read(16'hFFFF, 16'h0123);
`endif

    // Reset pulse in the middle of a WRITE cycle.
    @(posedge Clk); #1;
    ADDR = 16'h0300; Data_from_CPU = 16'h0777; Mem_WE = 1'b0;
    @(posedge Clk); #1;
    Mem_WE = 1'b1;
    chk("write_we_n_low", {31'h0, SRAM_WE_N}, 32'h0);
    #1 Reset = 1'b1;
    #1;
    chk("async_we_n", {31'h0, SRAM_WE_N}, 32'h1);
    chk("async_drive", {31'h0, SRAM_DQ_Drive}, 32'h0);
    chk("async_ce_n", {31'h0, SRAM_CE_N}, 32'h1);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    chk("post_rst_mdr", {16'h0, Data_to_CPU}, 32'h0);
`ifdef MEM_BRIDGE_IO_EN
    chk("post_rst_hex", {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, 7'h40, 7'h40, 7'h40, 7'h40});
`endif
    last_rd = 16'h0;
    do_read(16'h0300, 16'h0000);
    do_read(16'h0040, 16'h1234);

    repeat (2) @(posedge Clk);
    chk("wr_queue_drained", wr_q.size(), 32'h0);
    chk("rd_queue_drained", rd_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 SHALL have port Clk, input, 1, the single system clock; all state updates on the rising edge.
REQ-002 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port ADDR, input, 16, CPU address (MAR).
REQ-004 SHALL have port Data_from_CPU, input, 16, store data (MDR).
REQ-005 SHALL have port Mem_OE, input, 1, active-low read strobe from the control unit.
REQ-006 SHALL have port Mem_WE, input, 1, active-low write strobe from the control unit.
REQ-007 SHALL have port Switches, input, 16, board switches.
REQ-008 SHALL have port Data_to_CPU, output, 16, registered read data to MDR.
REQ-009 SHALL have port SRAM_ADDR, output, 20, SRAM address, zero-extended from 16 bits.
REQ-010 SHALL have port SRAM_CE_N, output, 1, active-low SRAM chip enable.
REQ-011 SHALL have port SRAM_OE_N, output, 1, active-low SRAM output enable.
REQ-012 SHALL have port SRAM_WE_N, output, 1, active-low SRAM write enable.
REQ-013 SHALL have port SRAM_DQ_In, input, 16, SRAM read data.
REQ-014 SHALL have port SRAM_DQ_Out, output, 16, SRAM write data.
REQ-015 SHALL have port SRAM_DQ_Drive, output, 1, tristate enable for SRAM_DQ_Out.
REQ-016 SHALL have ports HEX0, HEX1, HEX2 and HEX3, output, 7 each, active-low seven-segment digits (HEX0 = nibble 0).

Function
REQ-017 SHALL implement FSM states IDLE, READ, WRITE and WREC.
REQ-018 In IDLE with Mem_WE=0 (write wins over a simultaneous Mem_OE=0), SHALL latch ADDR and Data_from_CPU, then go to WRITE.
REQ-019 In IDLE with Mem_OE=0 and Mem_WE=1, SHALL capture the read source into Data_to_CPU at the clock edge, then go to READ.
REQ-020 In READ, SHALL recapture Data_to_CPU on every cycle while Mem_OE=0, and return to IDLE when Mem_OE=1.
- Result: read data is valid in the second consecutive Mem_OE-low cycle (the cycle in which MDR loads).
REQ-021 SRAM_OE_N SHALL equal Mem_OE in IDLE and READ, and SHALL be 1 in WRITE and WREC.
REQ-022 SRAM_ADDR SHALL be taken combinationally from ADDR in IDLE and READ, and from the latched address in WRITE and WREC.
REQ-023 WRITE SHALL last exactly 1 cycle: SRAM_WE_N=0, SRAM_DQ_Drive=1, SRAM_DQ_Out = latched data; next state WREC.
REQ-024 WREC SHALL last exactly 1 cycle: SRAM_WE_N=1, SRAM_DQ_Drive=0, Mem_OE ignored; next state IDLE.
REQ-025 SRAM_CE_N SHALL be 0 in every state except during reset.
REQ-026 SRAM_DQ_Drive and SRAM_WE_N=0 SHALL never be asserted in the same cycle as SRAM_OE_N=0.
REQ-027 Data_to_CPU SHALL hold its last value whenever no capture occurs.

Reset
REQ-028 While Reset=1, SHALL hold: state IDLE, Data_to_CPU=0, latched address/data=0, hex register=0, SRAM_CE_N=1, SRAM_OE_N=1, SRAM_WE_N=1, SRAM_DQ_Drive=0.
REQ-029 Reset asserted during WRITE SHALL deassert SRAM_WE_N immediately (asynchronously) and SHALL NOT update the hex register.

Configuration
REQ-030 When macro MEM_BRIDGE_IO_EN is defined, address 16'hFFFF SHALL be memory-mapped I/O:
- reads capture Switches instead of SRAM_DQ_In;
- the WRITE cycle loads the hex register from the latched data and suppresses SRAM_WE_N and SRAM_DQ_Drive;
- HEX0..HEX3 display the hex register.
REQ-031 When MEM_BRIDGE_IO_EN is undefined, 16'hFFFF SHALL be ordinary SRAM, Switches SHALL be unused, and HEX0..HEX3 SHALL be tied to 7'h7F (blank).

Structure
REQ-032 Package mem_bridge_pkg SHALL hold the state enum (2-bit), IO_ADDR=16'hFFFF, and the 16-entry seven-segment table.
REQ-033 Sub-module hex_decode (4-bit nibble to 7-bit active-low segments) SHALL be instantiated four times.

Verification
REQ-034 Read: SRAM[0x0040]=0x1234, Mem_OE low for 2 cycles with ADDR=0x0040 -> Data_to_CPU=0x1234 in the 2nd cycle; SRAM_WE_N stays 1.
REQ-035 Write: Mem_WE low for 1 cycle with ADDR=0x0100, data 0xBEEF -> next cycle SRAM_WE_N=0, DQ_Drive=1, SRAM_ADDR=0x00100, DQ_Out=0xBEEF; following cycle both deasserted; readback = 0xBEEF.
REQ-036 Simultaneous Mem_OE=0 and Mem_WE=0 in IDLE -> WRITE taken, SRAM_OE_N=1 during WRITE/WREC, Data_to_CPU unchanged.
REQ-037 With MEM_BRIDGE_IO_EN: Switches=0xA5C3, read 0xFFFF -> Data_to_CPU=0xA5C3; write 0x0123 to 0xFFFF -> HEX0=digit 3, HEX3=digit 0, SRAM_WE_N stays 1.
REQ-038 Reset pulsed during WRITE -> SRAM_WE_N=1 and DQ_Drive=0 within the same cycle, FSM in IDLE, hex register=0.
